mcu_readback: RTL and testbench
===============================

# mcu_readback

Read-direction counterpart of the MCU parallel write interface: lets the MCU read 48-bit values (live phase accumulators and control words of both AWG channels) back over the same 8-bit strobed bus. A control strobe carrying a readback command takes a coherent snapshot of the selected value. Each subsequent read strobe presents one byte, MSB first. Sits beside `mcu_interface` in `core_clock`. The top level owns the bidirectional pad and drives it from `o_data` when `o_data_oe` is high.

## Interface
- `BYTES`, 6: bytes per readback word (word width = 8*BYTES).
- `SYNC_STAGES`, 2: synchronizer depth for both strobes (minimum 2).

- `i_main_clk`  in  1  core clock; the only clock.
- `i_reset_n`  in  1  reset, synchronous, active-low.
- `i_control_strobe`  in  1  async, active-low; MCU command strobe.
- `i_read_strobe`  in  1  async, active-low; MCU read strobe.
- `i_data`  in  8  command byte from the MCU; stable while `i_control_strobe` is low.
- `i_channel1_signal_phase`  in  48  channel 1 live phase accumulator.
- `i_channel2_signal_phase`  in  48  channel 2 live phase accumulator.
- `i_channel1_signal_control`  in  48  channel 1 control word.
- `i_channel2_signal_control`  in  48  channel 2 control word.
- `o_data`  out  8  current readback byte.
- `o_data_oe`  out  1  pad drive enable.
- `o_busy`  out  1  high while a readback word is armed.

## Operation
- Each strobe passes through `SYNC_STAGES` flops plus one history flop. All of these reset to 1. Fall and rise are single-cycle pulses decoded from the last sync stage and the history flop.
- Command bytes:
  - 0x80 selects ch1 phase.
  - 0x81 selects ch2 phase.
  - 0x82 selects ch1 control.
  - 0x83 selects ch2 control.
  - All other values are write-path commands.
- State IDLE:
  - Control fall with a readback command: capture the selected 48-bit value into the snapshot register, set byte index = BYTES-1, go to ARMED.
  - Read strobes are ignored.
- State ARMED:
  - `o_data` = snapshot[8*idx+7 : 8*idx].
  - Read rise with idx > 0: idx decrements.
  - Read rise with idx = 0: go to IDLE.
  - Control fall with a readback command: re-snapshot and set idx = BYTES-1 (restart).
  - Control fall with a non-readback command: abort to IDLE.
- `o_data_oe` = (state == ARMED) AND synchronized read strobe low. It never asserts in IDLE.
- `o_busy` = (state == ARMED).
- Simultaneous control fall and read rise in the same cycle: the control action wins and the read rise is discarded.
- `o_data` is 0x00 in IDLE.
- Reset values:
  - State IDLE, idx 0, snapshot 0.
  - `o_data` = 0x00, `o_data_oe` = 0, `o_busy` = 0.
- Reset mid-word drops the snapshot; a new command is required.

## Timing
- A strobe first sampled low at edge n gives a fall pulse during cycle n+SYNC_STAGES-1. The state and snapshot register at edge n+SYNC_STAGES.
- With `SYNC_STAGES`=2: `o_busy` and the first byte are valid 2 edges after the control strobe is first sampled low.
- `o_data_oe` rises SYNC_STAGES edges after the read strobe is first sampled low. It falls SYNC_STAGES edges after the strobe is first sampled high.
- `o_data` changes only on the edge that consumes a read rise. It is therefore stable for the whole time `o_data_oe` is high.
- MCU requirements:
  - Each strobe low and high phase lasts at least SYNC_STAGES+2 core clocks.
  - Sample the bus no earlier than SYNC_STAGES+1 clocks after driving the read strobe low.
- The snapshot is taken in one cycle, so all 6 bytes come from the same clock edge. A phase accumulator updating every cycle still reads coherently.

## Structure
- Shared package `mcu_pkg` holds:
  - readback command constants 0x80..0x83;
  - the `READBACK_MASK` compare;
  - the state enum {IDLE, ARMED};
  - the default `BYTES` value.
- Sub-module `strobe_sync` (parameter `SYNC_STAGES`; outputs `level`, `fall`, `rise`) is instantiated twice. `mcu_interface` should migrate to it.
- The rest is a flat FSM, the snapshot mux/register and the byte selector. Expected size is about 150-250 lines.

## Test plan
- Reset, then toggle the read strobe 6 times -> `o_data_oe` stays 0, `o_busy` 0, `o_data` 0x00.
- ch1 phase = 0x0123_4567_89AB, command 0x80, 6 reads -> bytes 01,23,45,67,89,AB; `o_busy` falls after the 6th read's rising edge.
- ch2 phase increments every clock, command 0x81, 6 reads -> the bytes form exactly the value present at the snapshot edge.
- After 3 reads, command 0x82 -> the next 6 reads return the full ch1 control word from the MSB. Command 0x10 mid-word -> IDLE and `o_data_oe` never asserts.
- Control fall and read rise land in the same cycle -> the restart occurs and idx = 5, not 4.
- Reset asserted after 2 reads -> next cycle `o_busy`=0, `o_data`=0x00. A following command 0x83 -> the first byte is the MSB of ch2 control.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU parallel bus: readback command decode,
// readback FSM states and the default readback word length.
package mcu_pkg;

    localparam int BYTES_DEFAULT = 6;

    localparam logic [7:0] CMD_RB_CH1_PHASE   = 8'h80;
    localparam logic [7:0] CMD_RB_CH2_PHASE   = 8'h81;
    localparam logic [7:0] CMD_RB_CH1_CONTROL = 8'h82;
    localparam logic [7:0] CMD_RB_CH2_CONTROL = 8'h83;

    // Readback commands occupy 0x80..0x83; everything else belongs to the write path.
    localparam logic [7:0] READBACK_MASK  = 8'hFC;
    localparam logic [7:0] READBACK_MATCH = 8'h80;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } rb_state_t;

    function automatic logic is_readback(input logic [7:0] cmd);
        return (cmd & READBACK_MASK) == READBACK_MATCH;
    endfunction

endpackage

// File: rtl/strobe_sync.sv
// Synchronizer for an asynchronous active-low MCU strobe, with single-cycle
// fall/rise pulses decoded against a history flop. All flops reset high.
module strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_main_clk,
    input  logic i_reset_n,
    input  logic i_strobe_n,
    output logic level,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge i_main_clk) begin
        if (!i_reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_strobe_n};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign fall  = hist_q & ~level;
    assign rise  = ~hist_q & level;

endmodule

// File: rtl/mcu_readback.sv
// MCU readback path: a readback command snapshots one 48-bit AWG value, and
// successive read strobes shift it out one byte at a time, MSB first.
module mcu_readback
    import mcu_pkg::*;
#(
    parameter int BYTES       = BYTES_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_main_clk,
    input  logic                 i_reset_n,
    input  logic                 i_control_strobe,
    input  logic                 i_read_strobe,
    input  logic [7:0]           i_data,
    input  logic [8*BYTES-1:0]   i_channel1_signal_phase,
    input  logic [8*BYTES-1:0]   i_channel2_signal_phase,
    input  logic [8*BYTES-1:0]   i_channel1_signal_control,
    input  logic [8*BYTES-1:0]   i_channel2_signal_control,
    output logic [7:0]           o_data,
    output logic                 o_data_oe,
    output logic                 o_busy
);

    localparam int                WORD_W   = 8 * BYTES;
    localparam int                IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BYTES - 1);

    logic ctrl_level, ctrl_fall, ctrl_rise;
    logic read_level, read_fall, read_rise;

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ctrl_sync (
        .i_main_clk (i_main_clk),
        .i_reset_n  (i_reset_n),
        .i_strobe_n (i_control_strobe),
        .level      (ctrl_level),
        .fall       (ctrl_fall),
        .rise       (ctrl_rise)
    );

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_read_sync (
        .i_main_clk (i_main_clk),
        .i_reset_n  (i_reset_n),
        .i_strobe_n (i_read_strobe),
        .level      (read_level),
        .fall       (read_fall),
        .rise       (read_rise)
    );

    logic unused_strobe_bits;
    assign unused_strobe_bits = &{1'b0, ctrl_level, ctrl_rise, read_fall};

    rb_state_t          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  snap_q, snap_d;
    logic [WORD_W-1:0]  sel_word;
    logic [7:0]         byte_sel;
    logic               read_low_q;

    always_comb begin
        sel_word = '0;
        case (i_data)
            CMD_RB_CH1_PHASE:   sel_word = i_channel1_signal_phase;
            CMD_RB_CH2_PHASE:   sel_word = i_channel2_signal_phase;
            CMD_RB_CH1_CONTROL: sel_word = i_channel1_signal_control;
            CMD_RB_CH2_CONTROL: sel_word = i_channel2_signal_control;
            default:            sel_word = '0;
        endcase
    end

    always_ff @(posedge i_main_clk) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snap_q     <= '0;
            read_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            read_low_q <= ~read_level;
        end
    end

    // A control fall is handled before any read rise in the same cycle, so a
    // colliding read rise is simply dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (ctrl_fall && is_readback(i_data)) begin
                    state_d = ARMED;
                    idx_d   = IDX_LAST;
                    snap_d  = sel_word;
                end
            end
            ARMED: begin
                if (ctrl_fall) begin
                    if (is_readback(i_data)) begin
                        idx_d  = IDX_LAST;
                        snap_d = sel_word;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end else if (read_rise) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        byte_sel = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                byte_sel = snap_q[8*b +: 8];
            end
        end
    end

    assign o_busy    = (state_q == ARMED);
    assign o_data    = o_busy ? byte_sel : 8'h00;
    assign o_data_oe = o_busy & read_low_q;

endmodule

// File: tb/tb_mcu_readback.sv
// Bench for mcu_readback: directed scenarios plus a randomized command/read
// mix, checked against a byte-queue model of the readback word.
module tb_mcu_readback;

    localparam int SS   = 2;
    localparam int HOLD = SS + 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        ctrl_n = 1'b1;
    logic        read_n = 1'b1;
    logic [7:0]  cmd_bus = 8'h00;
    logic [47:0] ch1_ph = 48'h0;
    logic [47:0] ch2_ph = 48'h0000_FFFF_FFF0;
    logic [47:0] ch1_ct = 48'h0;
    logic [47:0] ch2_ct = 48'h0;
    logic [7:0]  rb_data;
    logic        rb_oe;
    logic        rb_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Bytes still to be read, MSB first; empty means no word is armed.
    logic [7:0] exp_q[$];

    mcu_readback #(.BYTES(6), .SYNC_STAGES(SS)) dut (
        .i_main_clk                (clk),
        .i_reset_n                 (rst_n),
        .i_control_strobe          (ctrl_n),
        .i_read_strobe             (read_n),
        .i_data                    (cmd_bus),
        .i_channel1_signal_phase   (ch1_ph),
        .i_channel2_signal_phase   (ch2_ph),
        .i_channel1_signal_control (ch1_ct),
        .i_channel2_signal_control (ch2_ct),
        .o_data                    (rb_data),
        .o_data_oe                 (rb_oe),
        .o_busy                    (rb_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ch2_ph <= ch2_ph + 48'd1;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input logic [47:0] w);
        exp_q.delete();
        for (int b = 5; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    function automatic logic [7:0] exp_byte();
        return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    endfunction

    function automatic logic is_rb(input logic [7:0] c);
        return (c >= 8'h80) && (c <= 8'h83);
    endfunction

    // Value the DUT should capture for command c if the strobe goes low now:
    // the capture edge is SS edges later, by which time ch2 phase has advanced SS.
    function automatic logic [47:0] value_for(input logic [7:0] c);
        case (c)
            8'h80:   return ch1_ph;
            8'h81:   return ch2_ph + 48'(SS);
            8'h82:   return ch1_ct;
            default: return ch2_ct;
        endcase
    endfunction

    task automatic model_cmd(input logic [7:0] c, input logic [47:0] w);
        if (is_rb(c)) model_load(w);
        else exp_q.delete();
    endtask

    task automatic control(input string tag, input logic [7:0] c);
        logic [47:0] w;
        cmd_bus = c;
        @(negedge clk);
        w = value_for(c);
        ctrl_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        model_cmd(c, w);
        check({tag, "_busy"}, 48'(rb_busy), 48'(exp_q.size() > 0));
        check({tag, "_data"}, 48'(rb_data), 48'(exp_byte()));
        check({tag, "_oe"},   48'(rb_oe),   48'(0));
        ctrl_n = 1'b1;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic read_one(input string tag);
        logic armed;
        read_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        armed = exp_q.size() > 0;
        check({tag, "_oe"},   48'(rb_oe),   48'(armed));
        check({tag, "_data"}, 48'(rb_data), 48'(exp_byte()));
        read_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        if (armed) void'(exp_q.pop_front());
        check({tag, "_busy"}, 48'(rb_busy), 48'(exp_q.size() > 0));
        check({tag, "_next"}, 48'(rb_data), 48'(exp_byte()));
    endtask

    initial begin
        logic [7:0]  c;
        logic [47:0] w;
        int          r;
        int          nrd;

        repeat (3) @(negedge clk);
        check("rst_busy", 48'(rb_busy), 48'(0));
        check("rst_oe",   48'(rb_oe),   48'(0));
        check("rst_data", 48'(rb_data), 48'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reads with nothing armed never drive the pad.
        for (int i = 0; i < 6; i++) read_one("idle_rd");

        // Fixed ch1 phase pattern.
        ch1_ph = 48'h0123_4567_89AB;
        control("cmd80", 8'h80);
        check("cmd80_msb", 48'(rb_data), 48'h01);
        for (int i = 0; i < 6; i++) read_one("ch1ph_rd");
        check("ch1ph_done", 48'(rb_busy), 48'(0));

        // Free-running ch2 phase must read back as one coherent value.
        control("cmd81", 8'h81);
        for (int i = 0; i < 6; i++) read_one("ch2ph_rd");

        // Restart mid-word with a different selection.
        ch1_ph = 48'({$urandom, $urandom});
        ch1_ct = 48'({$urandom, $urandom});
        control("cmd80b", 8'h80);
        for (int i = 0; i < 3; i++) read_one("part_rd");
        control("cmd82", 8'h82);
        for (int i = 0; i < 6; i++) read_one("ch1ct_rd");

        // Write-path command aborts an armed word.
        control("cmd80c", 8'h80);
        for (int i = 0; i < 2; i++) read_one("pre_abort_rd");
        control("cmd10", 8'h10);
        for (int i = 0; i < 2; i++) read_one("post_abort_rd");

        // Control fall and read rise in the same cycle: restart wins.
        ch2_ct = 48'({$urandom, $urandom});
        control("cmd83", 8'h83);
        for (int i = 0; i < 2; i++) read_one("coll_pre_rd");
        ch1_ph = 48'({$urandom, $urandom});
        cmd_bus = 8'h80;
        read_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("coll_low_data", 48'(rb_data), 48'(exp_byte()));
        w = value_for(8'h80);
        read_n = 1'b1;
        ctrl_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        model_load(w);
        check("coll_busy", 48'(rb_busy), 48'(1));
        check("coll_msb",  48'(rb_data), 48'(exp_byte()));
        ctrl_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        for (int i = 0; i < 6; i++) read_one("coll_rd");

        // Reset mid-word drops the snapshot.
        ch1_ct = 48'({$urandom, $urandom});
        control("cmd82b", 8'h82);
        for (int i = 0; i < 2; i++) read_one("prerst_rd");
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("midrst_busy", 48'(rb_busy), 48'(0));
        check("midrst_data", 48'(rb_data), 48'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Exact latency: busy and first byte two edges after first low sample.
        ch2_ct = 48'({$urandom, $urandom});
        cmd_bus = 8'h83;
        @(negedge clk);
        w = value_for(8'h83);
        ctrl_n = 1'b0;
        @(negedge clk);
        check("lat_busy_e0", 48'(rb_busy), 48'(0));
        @(negedge clk);
        check("lat_busy_e1", 48'(rb_busy), 48'(0));
        @(negedge clk);
        model_load(w);
        check("lat_busy_e2", 48'(rb_busy), 48'(1));
        check("lat_msb",     48'(rb_data), 48'(ch2_ct[47:40]));
        repeat (HOLD) @(negedge clk);
        ctrl_n = 1'b1;
        repeat (HOLD) @(negedge clk);

        read_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lat_oe_e1", 48'(rb_oe), 48'(0));
        @(negedge clk);
        check("lat_oe_e2", 48'(rb_oe), 48'(1));
        repeat (HOLD) @(negedge clk);
        read_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_oe_fall_e1", 48'(rb_oe), 48'(1));
        @(negedge clk);
        check("lat_oe_fall_e2", 48'(rb_oe), 48'(0));
        repeat (HOLD) @(negedge clk);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) read_one("lat_rd");

        // Randomized command/read mix.
        for (int it = 0; it < 16; it++) begin
            ch1_ph = 48'({$urandom, $urandom});
            ch1_ct = 48'({$urandom, $urandom});
            ch2_ct = 48'({$urandom, $urandom});
            r = int'($urandom_range(0, 5));
            if (r < 4) c = 8'h80 + 8'(r);
            else if (r == 4) c = 8'($urandom_range(0, 127));
            else c = 8'($urandom_range(132, 255));
            control("rnd_cmd", c);
            nrd = int'($urandom_range(0, 7));
            for (int i = 0; i < nrd; i++) read_one("rnd_rd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
